keypad_emulator: RTL and testbench
==================================

# keypad_emulator

Self-test keypad model driven by the scan lines of the keypad scanner. It replays a queued sequence of key codes as timed press/release events on the column lines, so the scanner and the safe controller can be exercised on-chip without a physical membrane keypad. It sits between the scanner's row outputs and its column inputs, muxed in place of the external keypad pins by the top level.

## Interface

Parameters:
- `DEPTH`, default 8: key-sequence FIFO entries (power of two, ≥2).
- `PRESS_CYCLES`, default 64: clk cycles a key is held.
- `RELEASE_CYCLES`, default 64: clk cycles of all-released gap after each key.

Ports:
- `clk` — in, 1 — single clock, rising edge.
- `rst_n` — in, 1 — reset, asynchronous, active-low.
- `row` — in, 3 — scanner row strobes, active-high, one-hot or zero.
- `col` — out, 4 — column lines returned to the scanner, active-high.
- `key_in` — in, 4 — key code to enqueue.
- `key_valid` — in, 1 — enqueue request.
- `key_ready` — out, 1 — enqueue accepted this cycle when high with `key_valid`.
- `start` — in, 1 — begin playback (single-cycle pulse).
- `abort` — in, 1 — synchronous flush and release.
- `busy` — out, 1 — playback in progress.
- `done` — out, 1 — one-cycle pulse when a sequence completes.
- `err` — out, 1 — sticky: an invalid code was skipped.

## Operation

Key map:
- Codes 0–11 are valid: row index = `code[3:2]`, column index = `code[1:0]`.
- Codes 12–15 are invalid.

Column drive:
- `col[c] = pressed && row[r_cur] && (c == c_cur)`. This is combinational from `row` and registered press state, matching a passive switch matrix.
- `col` is 0 whenever no key is pressed.

Loading:
- `key_ready = (state == IDLE) && !full`.
- A write occurs when `key_valid && key_ready`. Codes are stored unfiltered.

FSM, with state in a registered enum:
- **IDLE**
  - `start && count != 0` (count before this edge): pop the head, load the hold counter, go to PRESS.
  - Otherwise `start` is ignored.
  - A same-cycle write is still accepted and is played last.
- **PRESS**
  - If the popped code is invalid: `pressed` stays 0, `err` is set, and the FSM goes directly to RELEASE.
  - Otherwise `pressed = 1` for `PRESS_CYCLES` cycles, then go to RELEASE with the release counter loaded.
- **RELEASE**
  - `pressed = 0` for `RELEASE_CYCLES` cycles.
  - Then, if the FIFO is non-empty: pop and go to PRESS.
  - Otherwise: pulse `done`, go to IDLE.
- **abort** (any state): next edge sets `pressed = 0`, flushes the FIFO, goes to IDLE, and asserts no `done`. `err` is unchanged.

Flags:
- `busy = (state != IDLE)`.
- `err` clears only on reset.

Reset values:
- State = IDLE, FIFO empty, `pressed = 0`, counters = 0.
- Outputs: `col = 0`, `busy = 0`, `done = 0`, `err = 0`, `key_ready = 1`.

## Timing

- Start latency: with `start` sampled at edge N, `pressed` is high from edge N until edge N+`PRESS_CYCLES`.
- Per valid key, press-to-press spacing is exactly `PRESS_CYCLES + RELEASE_CYCLES` cycles.
- Invalid key: PRESS occupies 1 cycle, then the full RELEASE gap follows.
- `done` is asserted the cycle after the final release count expires, concurrent with the return to IDLE.
- FIFO behaviour:
  - Full: `key_ready = 0` and the write is dropped.
  - Wrap: read and write pointers are `log2(DEPTH)` bits with a separate count, so they wrap modulo `DEPTH`.
- `abort` has priority over `start` and over writes in the same cycle.
- Reset mid-press: `col` drops to 0 asynchronously, and the queue is lost.
- Counters are `$clog2(max(PRESS_CYCLES, RELEASE_CYCLES)+1)` bits wide and count down to 1.

## Structure

- Shared package `keypad_pkg`:
  - `KEY_ROWS = 3`, `KEY_COLS = 4`, `KEY_W = 4`, `KEY_MAX_VALID = 11`.
  - The FSM state enum (IDLE, PRESS, RELEASE).
  - A function mapping a code to row and column indices.
- One sub-module, `keyseq_fifo`:
  - Synchronous FIFO, `DEPTH` × `KEY_W`.
  - Signals: push, pop, flush, full, empty, count.
- The FSM, counters and column decode live in the top of the block. Target size is about 200 lines total.

## Test plan

1. Reset with `row = 3'b001`: `col = 0`, `key_ready = 1`, `busy = 0`, `err = 0`.
2. Enqueue 5, pulse `start`, drive `row = 3'b010` continuously: `col = 4'b0010` for exactly 64 cycles, then 0 for 64 cycles, then `done` pulses once and `busy` falls. With `row = 3'b001` instead, `col` stays 0 throughout.
3. Enqueue 1, 2, 3, 4, pulse `start`, sweep `row` one-hot each cycle: the scanner observes the keys in order 1, 2, 3, 4 with 128-cycle spacing, and `done` is asserted after the 4th release.
4. Enqueue 9 values with `DEPTH = 8`: the 9th sees `key_ready = 0` and is dropped. Playback yields exactly 8 keys in order, proving pointer wrap.
5. Enqueue 7, 14, 0, then start: code 14 causes no `col` activity and sets `err = 1`. Keys 7 and 0 play normally, `err` stays 1 after `done`.
6. Enqueue 3, 3 and start, then assert `abort` mid-press: `col = 0` next cycle, state returns to IDLE, FIFO empty, no `done` pulse. A subsequent `start` does nothing. Repeat with `rst_n` low mid-press: `col` falls without a clock edge.

Source files
------------

// File: rtl/keypad_pkg.sv
// Shared types and key-map helpers for the keypad emulator and its FIFO.
package keypad_pkg;

  localparam int KEY_ROWS      = 3;
  localparam int KEY_COLS      = 4;
  localparam int KEY_W         = 4;
  localparam int KEY_MAX_VALID = 11;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_PRESS   = 2'd1,
    ST_RELEASE = 2'd2
  } kp_state_e;

  typedef struct packed {
    logic [1:0] row_idx;
    logic [1:0] col_idx;
  } key_pos_t;

  function automatic key_pos_t key_to_pos(input logic [KEY_W-1:0] code);
    key_pos_t pos;
    pos.row_idx = code[3:2];
    pos.col_idx = code[1:0];
    return pos;
  endfunction

  function automatic logic key_is_valid(input logic [KEY_W-1:0] code);
    return code <= KEY_W'(KEY_MAX_VALID);
  endfunction

endpackage

// File: rtl/keypad_emulator_if.sv
// Scanner-side lines plus the sequence-loading and control handshake of the keypad emulator.
interface keypad_emulator_if;
  import keypad_pkg::*;

  logic [KEY_ROWS-1:0] row;
  logic [KEY_COLS-1:0] col;
  logic [KEY_W-1:0]    key_in;
  logic                key_valid;
  logic                key_ready;
  logic                start;
  logic                abort;
  logic                busy;
  logic                done;
  logic                err;

  modport master (
    output row, key_in, key_valid, start, abort,
    input  col, key_ready, busy, done, err
  );

  modport slave (
    input  row, key_in, key_valid, start, abort,
    output col, key_ready, busy, done, err
  );

endinterface

// File: rtl/keyseq_fifo.sv
// Synchronous key-code FIFO; pointers wrap modulo DEPTH, occupancy kept in a separate count.
module keyseq_fifo
  import keypad_pkg::*;
#(
  parameter  int DEPTH = 8,
  parameter  int W     = KEY_W,
  localparam int PW    = $clog2(DEPTH),
  localparam int CW    = $clog2(DEPTH + 1)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          push_i,
  input  logic          pop_i,
  input  logic          flush_i,
  input  logic [W-1:0]  wdata_i,
  output logic [W-1:0]  rdata_o,
  output logic          full_o,
  output logic          empty_o,
  output logic [CW-1:0] count_o
);

  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

  logic [W-1:0]  mem_q [DEPTH];
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          push_ok, pop_ok;

  assign full_o  = (count_q == DEPTH_C);
  assign empty_o = (count_q == '0);
  assign count_o = count_q;
  assign rdata_o = mem_q[rd_ptr_q];

  assign push_ok = push_i && !full_o && !flush_i;
  assign pop_ok  = pop_i && !empty_o && !flush_i;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush_i) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push_ok) wr_ptr_d = wr_ptr_q + PW'(1);
      if (pop_ok)  rd_ptr_d = rd_ptr_q + PW'(1);
      case ({push_ok, pop_ok})
        2'b10:   count_d = count_q + CW'(1);
        2'b01:   count_d = count_q - CW'(1);
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage is qualified by the count, so it needs no reset.
  always_ff @(posedge clk) begin
    if (push_ok) mem_q[wr_ptr_q] <= wdata_i;
  end

endmodule

// File: rtl/keypad_emulator.sv
// Replays queued key codes as timed press/release events on the scanner column lines,
// behaving like a passive switch matrix while a key is held.
module keypad_emulator
  import keypad_pkg::*;
#(
  parameter int DEPTH          = 8,
  parameter int PRESS_CYCLES   = 64,
  parameter int RELEASE_CYCLES = 64
) (
  input logic               clk,
  input logic               rst_n,
  keypad_emulator_if.slave  kp
);

  localparam int CNT_MAX = (PRESS_CYCLES > RELEASE_CYCLES) ? PRESS_CYCLES : RELEASE_CYCLES;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);
  localparam int FCW     = $clog2(DEPTH + 1);
  localparam logic [CNT_W-1:0] PRESS_LD = CNT_W'(PRESS_CYCLES);
  localparam logic [CNT_W-1:0] REL_LD   = CNT_W'(RELEASE_CYCLES);

  kp_state_e        state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [KEY_W-1:0] code_q, code_d;
  logic             pressed_q, pressed_d;
  logic             done_q, done_d;
  logic             err_q, err_d;

  logic             fifo_push, fifo_pop, fifo_full, fifo_empty;
  logic [KEY_W-1:0] fifo_rdata;
  logic [FCW-1:0]   fifo_count;

  key_pos_t            pos;
  logic [KEY_ROWS:0]   row_ext;
  logic [KEY_COLS-1:0] col_w;

  assign kp.key_ready = (state_q == ST_IDLE) && !fifo_full;
  assign fifo_push    = kp.key_valid && kp.key_ready && !kp.abort;

  keyseq_fifo #(
    .DEPTH (DEPTH),
    .W     (KEY_W)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .push_i  (fifo_push),
    .pop_i   (fifo_pop),
    .flush_i (kp.abort),
    .wdata_i (kp.key_in),
    .rdata_o (fifo_rdata),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .count_o (fifo_count)
  );

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    code_d    = code_q;
    pressed_d = pressed_q;
    done_d    = 1'b0;
    err_d     = err_q;
    fifo_pop  = 1'b0;
    if (kp.abort) begin
      state_d   = ST_IDLE;
      pressed_d = 1'b0;
      cnt_d     = '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (kp.start && (fifo_count != '0)) begin
            fifo_pop  = 1'b1;
            code_d    = fifo_rdata;
            pressed_d = key_is_valid(fifo_rdata);
            cnt_d     = PRESS_LD;
            state_d   = ST_PRESS;
          end
        end
        ST_PRESS: begin
          // An invalid code spends a single cycle here and never drives a column.
          if (!key_is_valid(code_q)) begin
            err_d     = 1'b1;
            pressed_d = 1'b0;
            cnt_d     = REL_LD;
            state_d   = ST_RELEASE;
          end else if (cnt_q <= CNT_W'(1)) begin
            pressed_d = 1'b0;
            cnt_d     = REL_LD;
            state_d   = ST_RELEASE;
          end else begin
            cnt_d = cnt_q - CNT_W'(1);
          end
        end
        ST_RELEASE: begin
          if (cnt_q <= CNT_W'(1)) begin
            if (!fifo_empty) begin
              fifo_pop  = 1'b1;
              code_d    = fifo_rdata;
              pressed_d = key_is_valid(fifo_rdata);
              cnt_d     = PRESS_LD;
              state_d   = ST_PRESS;
            end else begin
              done_d  = 1'b1;
              cnt_d   = '0;
              state_d = ST_IDLE;
            end
          end else begin
            cnt_d = cnt_q - CNT_W'(1);
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      cnt_q     <= '0;
      code_q    <= '0;
      pressed_q <= 1'b0;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      code_q    <= code_d;
      pressed_q <= pressed_d;
      done_q    <= done_d;
      err_q     <= err_d;
    end
  end

  // Combinational path from row to col mimics a closed membrane switch.
  assign pos     = key_to_pos(code_q);
  assign row_ext = {1'b0, kp.row};

  always_comb begin
    col_w = '0;
    if (pressed_q && row_ext[pos.row_idx]) col_w = KEY_COLS'(1) << pos.col_idx;
  end

  assign kp.col  = col_w;
  assign kp.busy = (state_q != ST_IDLE);
  assign kp.done = done_q;
  assign kp.err  = err_q;

endmodule

// File: tb/tb_keypad_emulator.sv
// Randomized bench for keypad_emulator against a timeline model of key playback.
module tb_keypad_emulator;

  localparam int DEPTH = 8;
  localparam int PC    = 64;
  localparam int RC    = 64;

  logic clk = 1'b0;
  logic rst_n;
  int   vectors = 0;
  int   miscompares = 0;
  logic [3:0] mq[$];
  logic       exp_err = 1'b0;

  always #5 clk = ~clk;

  keypad_emulator_if kif();

  keypad_emulator #(
    .DEPTH          (DEPTH),
    .PRESS_CYCLES   (PC),
    .RELEASE_CYCLES (RC)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .kp    (kif.slave)
  );

  function automatic bit code_ok(input logic [3:0] c);
    return c <= 4'd11;
  endfunction

  // Total cycles from the start edge until done: valid key P+R, invalid key 1+R.
  function automatic int play_len();
    int t = 0;
    foreach (mq[i]) t += code_ok(mq[i]) ? (PC + RC) : (1 + RC);
    return t;
  endfunction

  function automatic logic [3:0] exp_col(input int e, input logic [2:0] r);
    int t = 0;
    logic [3:0] c;
    foreach (mq[i]) begin
      c = mq[i];
      if (code_ok(c)) begin
        if (e >= t && e < t + PC) return r[int'(c) / 4] ? (4'b0001 << c[1:0]) : 4'b0000;
        t += PC + RC;
      end else begin
        t += 1 + RC;
      end
    end
    return 4'b0000;
  endfunction

  task automatic push_key(input logic [3:0] c, output logic rdy);
    @(negedge clk);
    kif.key_in    = c;
    kif.key_valid = 1'b1;
    #1 rdy = kif.key_ready;
    @(negedge clk);
    kif.key_valid = 1'b0;
  endtask

  task automatic push_checked(input string name, input logic [3:0] c);
    logic rdy;
    logic exp_rdy;
    exp_rdy = (mq.size() < DEPTH);
    push_key(c, rdy);
    vectors++;
    if (rdy !== exp_rdy) begin
      miscompares++;
      $display("FAIL %s key_ready code=%0d: got %b want %b", name, c, rdy, exp_rdy);
    end
    if (exp_rdy) mq.push_back(c);
  endtask

  task automatic pulse_start();
    @(negedge clk);
    kif.start = 1'b1;
    @(negedge clk);
    kif.start = 1'b0;
  endtask

  // mode 0: fixed row, 1: one-hot sweep, 2: random one-hot or zero
  task automatic run_playback(input string name, input int mode, input logic [2:0] fixed_row);
    int len, dones, pick;
    logic [2:0] r;
    logic [3:0] ec;
    len = play_len();
    dones = 0;
    pulse_start();
    for (int e = 0; e <= len + 2; e++) begin
      case (mode)
        0: r = fixed_row;
        1: r = 3'(1 << (e % 3));
        default: begin
          pick = $urandom_range(0, 3);
          r = (pick == 0) ? 3'b000 : 3'(1 << (pick - 1));
        end
      endcase
      kif.row = r;
      #1;
      ec = exp_col(e, r);
      vectors++;
      if (kif.col !== ec) begin
        miscompares++;
        $display("FAIL %s col e=%0d row=%b: got %b want %b", name, e, r, kif.col, ec);
      end
      vectors++;
      if (kif.busy !== (e < len)) begin
        miscompares++;
        $display("FAIL %s busy e=%0d: got %b want %b", name, e, kif.busy, (e < len));
      end
      vectors++;
      if (kif.done !== (e == len)) begin
        miscompares++;
        $display("FAIL %s done e=%0d: got %b want %b", name, e, kif.done, (e == len));
      end
      if (kif.done === 1'b1) dones++;
      @(negedge clk);
    end
    foreach (mq[i]) if (!code_ok(mq[i])) exp_err = 1'b1;
    mq.delete();
    vectors++;
    if (dones != 1) begin
      miscompares++;
      $display("FAIL %s done_count: got %0d want 1", name, dones);
    end
    vectors++;
    if (kif.err !== exp_err) begin
      miscompares++;
      $display("FAIL %s err_after: got %b want %b", name, kif.err, exp_err);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    kif.row = 3'b001;
    kif.key_in = '0;
    kif.key_valid = 1'b0;
    kif.start = 1'b0;
    kif.abort = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    vectors += 5;
    if (kif.col !== 4'b0000) begin miscompares++; $display("FAIL reset col: got %b want 0000", kif.col); end
    if (kif.key_ready !== 1'b1) begin miscompares++; $display("FAIL reset key_ready: got %b want 1", kif.key_ready); end
    if (kif.busy !== 1'b0) begin miscompares++; $display("FAIL reset busy: got %b want 0", kif.busy); end
    if (kif.err !== 1'b0) begin miscompares++; $display("FAIL reset err: got %b want 0", kif.err); end
    if (kif.done !== 1'b0) begin miscompares++; $display("FAIL reset done: got %b want 0", kif.done); end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_single_key();
    push_checked("single", 4'd5);
    run_playback("single_row1", 0, 3'b010);
    push_checked("single", 4'd5);
    run_playback("single_row0", 0, 3'b001);
  endtask

  task automatic test_sequence();
    for (int k = 1; k <= 4; k++) push_checked("sequence", 4'(k));
    run_playback("sequence_sweep", 1, 3'b000);
  endtask

  task automatic test_fifo_wrap();
    for (int k = 0; k < DEPTH + 1; k++) push_checked("wrap", 4'($urandom_range(0, 11)));
    run_playback("wrap_play", 2, 3'b000);
  endtask

  task automatic test_invalid();
    vectors++;
    if (kif.err !== exp_err) begin
      miscompares++;
      $display("FAIL invalid err_before: got %b want %b", kif.err, exp_err);
    end
    push_checked("invalid", 4'd7);
    push_checked("invalid", 4'd14);
    push_checked("invalid", 4'd0);
    run_playback("invalid_play", 1, 3'b000);
  endtask

  task automatic test_random();
    int n;
    for (int it = 0; it < 3; it++) begin
      n = $urandom_range(1, 5);
      for (int k = 0; k < n; k++) push_checked("random", 4'($urandom_range(0, 15)));
      run_playback("random_play", 2, 3'b000);
    end
  endtask

  task automatic test_abort();
    int dones;
    push_checked("abort", 4'd3);
    push_checked("abort", 4'd3);
    kif.row = 3'b001;
    pulse_start();
    repeat (10) @(negedge clk);
    #1;
    vectors++;
    if (kif.col !== 4'b1000) begin miscompares++; $display("FAIL abort col_pressed: got %b want 1000", kif.col); end
    @(negedge clk);
    kif.abort = 1'b1;
    @(negedge clk);
    kif.abort = 1'b0;
    #1;
    vectors += 3;
    if (kif.col !== 4'b0000) begin miscompares++; $display("FAIL abort col_after: got %b want 0000", kif.col); end
    if (kif.busy !== 1'b0) begin miscompares++; $display("FAIL abort busy_after: got %b want 0", kif.busy); end
    if (kif.key_ready !== 1'b1) begin miscompares++; $display("FAIL abort key_ready: got %b want 1", kif.key_ready); end
    mq.delete();
    dones = 0;
    repeat (200) begin
      @(negedge clk);
      #1;
      if (kif.done === 1'b1) dones++;
    end
    vectors++;
    if (dones != 0) begin miscompares++; $display("FAIL abort done_count: got %0d want 0", dones); end
    pulse_start();
    for (int k = 0; k < 5; k++) begin
      #1;
      vectors++;
      if (kif.busy !== 1'b0 || kif.col !== 4'b0000) begin
        miscompares++;
        $display("FAIL abort restart_busy k=%0d: got busy=%b col=%b want busy=0 col=0000", k, kif.busy, kif.col);
      end
      @(negedge clk);
    end
    vectors++;
    if (kif.err !== exp_err) begin miscompares++; $display("FAIL abort err: got %b want %b", kif.err, exp_err); end
  endtask

  task automatic test_reset_mid_press();
    push_checked("rst_mid", 4'd3);
    push_checked("rst_mid", 4'd6);
    kif.row = 3'b001;
    pulse_start();
    repeat (5) @(negedge clk);
    #1;
    vectors++;
    if (kif.col !== 4'b1000) begin miscompares++; $display("FAIL rst_mid col_pressed: got %b want 1000", kif.col); end
    #2 rst_n = 1'b0;
    #1;
    vectors += 4;
    if (kif.col !== 4'b0000) begin miscompares++; $display("FAIL rst_mid col_async: got %b want 0000", kif.col); end
    if (kif.busy !== 1'b0) begin miscompares++; $display("FAIL rst_mid busy: got %b want 0", kif.busy); end
    if (kif.err !== 1'b0) begin miscompares++; $display("FAIL rst_mid err: got %b want 0", kif.err); end
    if (kif.key_ready !== 1'b1) begin miscompares++; $display("FAIL rst_mid key_ready: got %b want 1", kif.key_ready); end
    exp_err = 1'b0;
    mq.delete();
    @(negedge clk);
    rst_n = 1'b1;
    pulse_start();
    for (int k = 0; k < 5; k++) begin
      #1;
      vectors++;
      if (kif.busy !== 1'b0) begin
        miscompares++;
        $display("FAIL rst_mid restart_busy k=%0d: got %b want 0", k, kif.busy);
      end
      @(negedge clk);
    end
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares + 1);
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_single_key();
    test_sequence();
    test_fifo_wrap();
    test_invalid();
    test_random();
    test_abort();
    test_reset_mid_press();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
